// File: rtl/prog_loader.sv
// Program loader: buffers host instruction words, then replays them into the processor
// as a burst of load pulses before switching the processor into execute mode.
module prog_loader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_valid,
  input  logic [IW-1:0] host_data,
  output logic          host_ready,
  input  logic          start,
  input  logic          abort,
  output logic          state,
  output logic          load,
  output logic [IW-1:0] instr,
  output logic          busy,
  output logic [4:0]    count
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DepthCnt = 5'(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StRun} fsm_e;

  fsm_e          fsm_q;
  logic [4:0]    wr_ptr_q;
  logic [4:0]    rd_ptr_q;
  logic [IW-1:0] prog_mem [DEPTH];

  logic          xfer;
  logic          launch;
  logic [IW-1:0] first_word;

  always_comb begin
    host_ready = (fsm_q == StIdle) && (count < DepthCnt);
    xfer       = host_valid && host_ready && !abort;
    launch     = (fsm_q == StIdle) && start && !abort && ((count != 5'd0) || xfer);
    // An empty buffer can only launch on a same-cycle write, so word 0 is still on the bus.
    first_word = (count == 5'd0) ? host_data : prog_mem[0];
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      prog_mem[wr_ptr_q[AW-1:0]] <= host_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= StIdle;
      wr_ptr_q <= 5'd0;
      rd_ptr_q <= 5'd0;
      count    <= 5'd0;
      state    <= 1'b0;
      load     <= 1'b0;
      instr    <= '0;
      busy     <= 1'b0;
    end else if (abort) begin
      fsm_q    <= StIdle;
      wr_ptr_q <= 5'd0;
      rd_ptr_q <= 5'd0;
      count    <= 5'd0;
      state    <= 1'b0;
      load     <= 1'b0;
      instr    <= '0;
      busy     <= 1'b0;
    end else begin
      case (fsm_q)
        StIdle: begin
          if (xfer) begin
            wr_ptr_q <= wr_ptr_q + 5'd1;
            count    <= count + 5'd1;
          end
          // Word 0 goes out on the launch edge; rd_ptr_q then names the next word to issue.
          if (launch) begin
            fsm_q    <= StIssue;
            busy     <= 1'b1;
            load     <= 1'b1;
            state    <= 1'b0;
            instr    <= first_word;
            rd_ptr_q <= 5'd1;
          end
        end
        StIssue: begin
          if (rd_ptr_q == count) begin
            fsm_q <= StRun;
            load  <= 1'b0;
            state <= 1'b1;
          end else begin
            instr    <= prog_mem[rd_ptr_q[AW-1:0]];
            rd_ptr_q <= rd_ptr_q + 5'd1;
          end
        end
        StRun: begin
          fsm_q <= StRun;
        end
        default: begin
          fsm_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed scenarios plus random traffic against a queue-based model.
module tb_prog_loader;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;
  logic       start;
  logic       abort;
  logic       state;
  logic       load;
  logic [7:0] instr;
  logic       busy;
  logic [4:0] count;

  int vectors = 0;
  int miscompares = 0;

  // Model: buffered program, words still to replay, and expected registered outputs.
  logic [7:0] prog[$];
  logic [7:0] pend[$];
  logic       m_load;
  logic       m_state;
  logic       m_busy;
  logic [7:0] m_instr;

  prog_loader #(.DEPTH(DEPTH), .IW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .start      (start),
    .abort      (abort),
    .state      (state),
    .load       (load),
    .instr      (instr),
    .busy       (busy),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    prog.delete();
    pend.delete();
    m_load  = 1'b0;
    m_state = 1'b0;
    m_busy  = 1'b0;
    m_instr = 8'h00;
  endtask

  task automatic model_step(input logic hv, input logic [7:0] hd, input logic st,
                            input logic ab);
    if (ab) begin
      model_clear();
    end else if (!m_busy) begin
      if (hv && prog.size() < DEPTH) prog.push_back(hd);
      if (st && prog.size() > 0) begin
        pend    = prog;
        m_instr = pend.pop_front();
        m_load  = 1'b1;
        m_state = 1'b0;
        m_busy  = 1'b1;
      end
    end else if (pend.size() > 0) begin
      m_instr = pend.pop_front();
      m_load  = 1'b1;
    end else if (m_load) begin
      m_load  = 1'b0;
      m_state = 1'b1;
    end
  endtask

  task automatic check_outs(input string ctx);
    chk({ctx, ".load"},  32'(load),  32'(m_load));
    chk({ctx, ".state"}, 32'(state), 32'(m_state));
    chk({ctx, ".instr"}, 32'(instr), 32'(m_instr));
    chk({ctx, ".busy"},  32'(busy),  32'(m_busy));
    chk({ctx, ".count"}, 32'(count), 32'(prog.size()));
  endtask

  // One clock: drive on the falling edge, check ready, then check registered outputs after the edge.
  task automatic step(input string ctx, input logic hv, input logic [7:0] hd, input logic st,
                      input logic ab);
    logic exp_ready;
    @(negedge clk);
    host_valid = hv;
    host_data  = hd;
    start      = st;
    abort      = ab;
    exp_ready  = !m_busy && (prog.size() < DEPTH);
    #1;
    chk({ctx, ".host_ready"}, 32'(host_ready), 32'(exp_ready));
    @(posedge clk);
    model_step(hv, hd, st, ab);
    #1;
    check_outs(ctx);
  endtask

  task automatic idle_cycles(input string ctx, input int n);
    for (int i = 0; i < n; i++) step(ctx, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    host_valid = 1'b0;
    host_data  = 8'h00;
    start      = 1'b0;
    abort      = 1'b0;
    model_clear();
    #3;
    check_outs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset.host_ready", 32'(host_ready), 32'd1);

    // Three-word program replay.
    step("w3", 1'b1, 8'h11, 1'b0, 1'b0);
    step("w3", 1'b1, 8'h22, 1'b0, 1'b0);
    step("w3", 1'b1, 8'h33, 1'b0, 1'b0);
    step("w3.start", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("w3.first_instr", 32'(instr), 32'h11);
    step("w3.iss1", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("w3.second_instr", 32'(instr), 32'h22);
    step("w3.iss2", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("w3.third_instr", 32'(instr), 32'h33);
    step("w3.run", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("w3.run_state", 32'(state), 32'd1);
    chk("w3.run_instr", 32'(instr), 32'h33);
    step("w3.run_start", 1'b1, 8'h44, 1'b1, 1'b0);
    step("w3.abort", 1'b0, 8'h00, 1'b0, 1'b1);

    // Fill to capacity with valid held through a 17th word, then replay all 16.
    for (int i = 0; i < 17; i++) step("full", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("full.count", 32'(count), 32'd16);
    step("full.start", 1'b0, 8'h00, 1'b1, 1'b0);
    idle_cycles("full.replay", 18);
    step("full.abort", 1'b0, 8'h00, 1'b0, 1'b1);

    // Empty start ignored; same-cycle write and start issues that word.
    step("empty.start", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty.busy", 32'(busy), 32'd0);
    step("same.start", 1'b1, 8'hA5, 1'b1, 1'b0);
    chk("same.instr", 32'(instr), 32'hA5);
    idle_cycles("same.run", 2);
    step("same.abort", 1'b0, 8'h00, 1'b0, 1'b1);

    // Abort midway through a four-word replay.
    for (int i = 0; i < 4; i++) step("mid", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step("mid.start", 1'b0, 8'h00, 1'b1, 1'b0);
    step("mid.iss", 1'b0, 8'h00, 1'b0, 1'b0);
    step("mid.abort", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("mid.abort_load", 32'(load), 32'd0);
    chk("mid.abort_count", 32'(count), 32'd0);
    step("mid.restart", 1'b0, 8'h00, 1'b1, 1'b0);

    // Abort beats start, and a same-cycle write is discarded.
    for (int i = 0; i < 3; i++) step("ab_st", 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step("ab_st.both", 1'b1, 8'h7F, 1'b1, 1'b1);
    chk("ab_st.count", 32'(count), 32'd0);
    idle_cycles("ab_st.after", 2);

    // Asynchronous reset pulse during RUN.
    step("arst", 1'b1, 8'h91, 1'b0, 1'b0);
    step("arst", 1'b1, 8'h92, 1'b0, 1'b0);
    step("arst.start", 1'b0, 8'h00, 1'b1, 1'b0);
    idle_cycles("arst.run", 3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.state", 32'(state), 32'd0);
    chk("arst.load", 32'(load), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.count", 32'(count), 32'd0);
    model_clear();
    #1;
    rst = 1'b0;
    #1;
    chk("arst.host_ready", 32'(host_ready), 32'd1);
    idle_cycles("arst.after", 2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
